// File: rtl/mc_ctrl_if.sv
// Control-unit bus for mc_ctrl: instruction/status inputs and datapath strobes.
// master is the controller side, slave is the datapath side.
interface mc_ctrl_if;
   logic [31:0] Ins;
   logic        Zero;
   logic        MemReady;
   logic        PCWrite;
   logic        IRWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        RegWrite;
   logic [1:0]  RegDst;
   logic [1:0]  WdSel;
   logic        ExtSel;
   logic [1:0]  ALUSrcB;
   logic [1:0]  PCSrc;
   logic [3:0]  State;
   logic        Trap;
   logic [31:0] InsCount;

   modport master (
      input  Ins, Zero, MemReady,
      output PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
      output RegDst, WdSel, ExtSel, ALUSrcB, PCSrc, State, Trap, InsCount
   );

   modport slave (
      output Ins, Zero, MemReady,
      input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
      input  RegDst, WdSel, ExtSel, ALUSrcB, PCSrc, State, Trap, InsCount
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: registered state, trap and retired count;
// datapath strobes decoded combinationally from State, Ins, Zero and MemReady.
module mc_ctrl #(
   parameter logic [5:0] R_FORM = 6'd0,
   parameter logic [5:0] J      = 6'd2,
   parameter logic [5:0] JAL    = 6'd3,
   parameter logic [5:0] BEQ    = 6'd4,
   parameter logic [5:0] ADDI   = 6'd8,
   parameter logic [5:0] ANDI   = 6'd12,
   parameter logic [5:0] ORI    = 6'd13,
   parameter logic [5:0] XORI   = 6'd14,
   parameter logic [5:0] LW     = 6'd35,
   parameter logic [5:0] SW     = 6'd43,
   parameter logic [5:0] JR     = 6'd8
) (
   input logic       CLK,
   input logic       RST,
   mc_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StExecR  = 4'd2,
      StExecI  = 4'd3,
      StAddr   = 4'd4,
      StMemRd  = 4'd5,
      StMemWr  = 4'd6,
      StWb     = 4'd7,
      StBr     = 4'd8,
      StLink   = 4'd9,
      StHalt   = 4'd15
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_trap;
   logic [31:0] r_ins_count;

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [4:0]  w_waddr;
   logic        w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write_raw;
   logic [1:0]  w_reg_dst, w_wd_sel, w_alu_src_b, w_pc_src;
   logic        w_unused_ins;

   assign w_op         = bus.Ins[31:26];
   assign w_funct      = bus.Ins[5:0];
   assign w_unused_ins = ^{bus.Ins[25:21], bus.Ins[10:6]};

   always_comb begin
      w_pc_write      = 1'b0;
      w_ir_write      = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_reg_write_raw = 1'b0;
      w_reg_dst       = 2'd0;
      w_wd_sel        = 2'd0;
      w_alu_src_b     = 2'd0;
      w_pc_src        = 2'd0;
      w_next          = r_state;
      case (r_state)
         StFetch: begin
            w_mem_read = 1'b1;
            if (bus.MemReady) begin
               w_ir_write  = 1'b1;
               w_pc_write  = 1'b1;
               w_alu_src_b = 2'd1;
               w_next      = StDecode;
            end
         end
         StDecode: begin
            if (w_op == J) begin
               w_pc_write = 1'b1;
               w_pc_src   = 2'd2;
               w_next     = StFetch;
            end else if (w_op == JAL) begin
               w_pc_write = 1'b1;
               w_pc_src   = 2'd2;
               w_next     = StLink;
            end else if (w_op == R_FORM) begin
               if (w_funct == JR) begin
                  w_pc_write = 1'b1;
                  w_pc_src   = 2'd3;
                  w_next     = StFetch;
               end else begin
                  w_next = StExecR;
               end
            end else if (w_op == ADDI || w_op == ANDI || w_op == ORI || w_op == XORI) begin
               w_next = StExecI;
            end else if (w_op == LW || w_op == SW) begin
               w_next = StAddr;
            end else if (w_op == BEQ) begin
               w_next = StBr;
            end else begin
               w_next = StHalt;
            end
         end
         StExecR: w_next = StWb;
         StExecI: begin
            w_alu_src_b = 2'd2;
            w_next      = StWb;
         end
         StAddr: begin
            w_alu_src_b = 2'd2;
            w_next      = (w_op == LW) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            w_mem_read = 1'b1;
            if (bus.MemReady) w_next = StWb;
         end
         StMemWr: begin
            w_mem_write = 1'b1;
            if (bus.MemReady) w_next = StFetch;
         end
         StWb: begin
            w_reg_write_raw = 1'b1;
            w_reg_dst       = (w_op == R_FORM) ? 2'd1 : 2'd0;
            w_wd_sel        = (w_op == LW) ? 2'd1 : 2'd0;
            w_next          = StFetch;
         end
         StBr: begin
            if (bus.Zero) begin
               w_pc_write = 1'b1;
               w_pc_src   = 2'd1;
            end
            w_next = StFetch;
         end
         StLink: begin
            w_reg_write_raw = 1'b1;
            w_reg_dst       = 2'd2;
            w_wd_sel        = 2'd2;
            w_next          = StFetch;
         end
         StHalt:  w_next = StHalt;
         default: w_next = StHalt;
      endcase
   end

   // Register 0 is hardwired, so a write aimed at it is suppressed.
   always_comb begin
      unique case (w_reg_dst)
         2'd1:    w_waddr = bus.Ins[15:11];
         2'd2:    w_waddr = 5'd31;
         default: w_waddr = bus.Ins[20:16];
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= StFetch;
         r_trap      <= 1'b0;
         r_ins_count <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_next == StHalt) r_trap <= 1'b1;
         if (r_state != StFetch && w_next == StFetch) r_ins_count <= r_ins_count + 32'd1;
      end
   end

   assign bus.PCWrite  = w_pc_write;
   assign bus.IRWrite  = w_ir_write;
   assign bus.MemRead  = w_mem_read;
   assign bus.MemWrite = w_mem_write;
   assign bus.RegWrite = w_reg_write_raw && (w_waddr != 5'd0);
   assign bus.RegDst   = w_reg_dst;
   assign bus.WdSel    = w_wd_sel;
   assign bus.ExtSel   = (w_op == ANDI) || (w_op == ORI) || (w_op == XORI);
   assign bus.ALUSrcB  = w_alu_src_b;
   assign bus.PCSrc    = w_pc_src;
   assign bus.State    = r_state;
   assign bus.Trap     = r_trap;
   assign bus.InsCount = r_ins_count;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed vector bench for mc_ctrl: table of per-cycle inputs and expected
// state/strobes/count, plus memory-stall, halt and reset sequences.
module tb_mc_ctrl;
   logic CLK = 1'b0;
   logic RST = 1'b1;

   mc_ctrl_if bus ();

   mc_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.master)
   );

   always #5 CLK = ~CLK;

   localparam logic [31:0] I_ADD  = 32'h014B4020;
   localparam logic [31:0] I_ADD0 = 32'h016B0020;
   localparam logic [31:0] I_ORI  = 32'h3508FFFF;
   localparam logic [31:0] I_ADDI = 32'h2108FFFF;
   localparam logic [31:0] I_J    = 32'h08000004;
   localparam logic [31:0] I_BEQ  = 32'h11490003;
   localparam logic [31:0] I_JAL  = 32'h0C000010;
   localparam logic [31:0] I_JR   = 32'h03E00008;
   localparam logic [31:0] I_SW   = 32'hAFA90004;
   localparam logic [31:0] I_LW   = 32'h8FA90004;
   localparam logic [31:0] I_BAD  = 32'hFC000000;

   // sig = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, WdSel, ExtSel, ALUSrcB, PCSrc}
   typedef struct {
      logic [31:0] ins;
      logic        zero;
      logic        rdy;
      logic [3:0]  st;
      logic [13:0] sig;
      logic [31:0] cnt;
   } vec_t;

   vec_t tv[48];
   int   n_tv  = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic [31:0] ins, input int z, r, st,
                               pcw, irw, mr, mw, rw, rdst, wds, ext, srcb, psrc, cnt);
      vec_t v;
      v.ins  = ins;
      v.zero = (z != 0);
      v.rdy  = (r != 0);
      v.st   = 4'(st);
      v.sig  = {pcw != 0, irw != 0, mr != 0, mw != 0, rw != 0,
                2'(rdst), 2'(wds), ext != 0, 2'(srcb), 2'(psrc)};
      v.cnt  = 32'(cnt);
      return v;
   endfunction

   task automatic add(input vec_t e);
      tv[n_tv] = e;
      n_tv++;
   endtask

   task automatic cmp(input string name, input int step, input logic [31:0] got, want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h want %0h", name, step, got, want);
      end
   endtask

   // Called at a negedge: drive inputs, check mid-low phase, advance to next negedge.
   task automatic run_vec(input vec_t e, input int step);
      logic [13:0] act;
      bus.Ins      = e.ins;
      bus.Zero     = e.zero;
      bus.MemReady = e.rdy;
      #2;
      act = {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite,
             bus.RegDst, bus.WdSel, bus.ExtSel, bus.ALUSrcB, bus.PCSrc};
      cmp("state", step, 32'(bus.State), 32'(e.st));
      cmp("strobes", step, 32'(act), 32'(e.sig));
      cmp("inscount", step, bus.InsCount, e.cnt);
      cmp("trap", step, 32'(bus.Trap), 32'(e.st == 4'd15));
      @(negedge CLK);
   endtask

   task automatic pulse_reset();
      RST          = 1'b1;
      bus.MemReady = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      bus.Ins      = 32'd0;
      bus.Zero     = 1'b0;
      bus.MemReady = 1'b0;

      //      ins     z r st pcw irw mr mw rw dst wd ext srcb psrc cnt
      add(mk(I_ADD,  0,1, 0,  1,1,1,0,0,  0,0,0,1,0,  0));
      add(mk(I_ADD,  0,1, 1,  0,0,0,0,0,  0,0,0,0,0,  0));
      add(mk(I_ADD,  0,1, 2,  0,0,0,0,0,  0,0,0,0,0,  0));
      add(mk(I_ADD,  0,1, 7,  0,0,0,0,1,  1,0,0,0,0,  0));
      add(mk(I_ORI,  0,1, 0,  1,1,1,0,0,  0,0,1,1,0,  1));
      add(mk(I_ORI,  0,1, 1,  0,0,0,0,0,  0,0,1,0,0,  1));
      add(mk(I_ORI,  0,1, 3,  0,0,0,0,0,  0,0,1,2,0,  1));
      add(mk(I_ORI,  0,1, 7,  0,0,0,0,1,  0,0,1,0,0,  1));
      add(mk(I_ADDI, 0,1, 0,  1,1,1,0,0,  0,0,0,1,0,  2));
      add(mk(I_ADDI, 0,1, 1,  0,0,0,0,0,  0,0,0,0,0,  2));
      add(mk(I_ADDI, 0,1, 3,  0,0,0,0,0,  0,0,0,2,0,  2));
      add(mk(I_ADDI, 0,1, 7,  0,0,0,0,1,  0,0,0,0,0,  2));
      add(mk(I_J,    0,1, 0,  1,1,1,0,0,  0,0,0,1,0,  3));
      add(mk(I_J,    0,1, 1,  1,0,0,0,0,  0,0,0,0,2,  3));
      add(mk(I_BEQ,  0,1, 0,  1,1,1,0,0,  0,0,0,1,0,  4));
      add(mk(I_BEQ,  0,1, 1,  0,0,0,0,0,  0,0,0,0,0,  4));
      add(mk(I_BEQ,  0,1, 8,  0,0,0,0,0,  0,0,0,0,0,  4));
      add(mk(I_BEQ,  1,1, 0,  1,1,1,0,0,  0,0,0,1,0,  5));
      add(mk(I_BEQ,  1,1, 1,  0,0,0,0,0,  0,0,0,0,0,  5));
      add(mk(I_BEQ,  1,1, 8,  1,0,0,0,0,  0,0,0,0,1,  5));
      add(mk(I_JAL,  0,1, 0,  1,1,1,0,0,  0,0,0,1,0,  6));
      add(mk(I_JAL,  0,1, 1,  1,0,0,0,0,  0,0,0,0,2,  6));
      add(mk(I_JAL,  0,1, 9,  0,0,0,0,1,  2,2,0,0,0,  6));
      add(mk(I_JR,   0,1, 0,  1,1,1,0,0,  0,0,0,1,0,  7));
      add(mk(I_JR,   0,1, 1,  1,0,0,0,0,  0,0,0,0,3,  7));
      add(mk(I_SW,   0,1, 0,  1,1,1,0,0,  0,0,0,1,0,  8));
      add(mk(I_SW,   0,1, 1,  0,0,0,0,0,  0,0,0,0,0,  8));
      add(mk(I_SW,   0,1, 4,  0,0,0,0,0,  0,0,0,2,0,  8));
      add(mk(I_SW,   0,1, 6,  0,0,0,1,0,  0,0,0,0,0,  8));
      add(mk(I_ADD0, 0,1, 0,  1,1,1,0,0,  0,0,0,1,0,  9));
      add(mk(I_ADD0, 0,1, 1,  0,0,0,0,0,  0,0,0,0,0,  9));
      add(mk(I_ADD0, 0,1, 2,  0,0,0,0,0,  0,0,0,0,0,  9));
      add(mk(I_ADD0, 0,1, 7,  0,0,0,0,0,  1,0,0,0,0,  9));

      // Reset held through the first posedge; check the first FETCH cycle.
      @(negedge CLK);
      RST = 1'b0;
      run_vec(mk(32'd0, 0,0, 0,  0,0,1,0,0,  0,0,0,0,0,  0), 0);

      for (int i = 0; i < n_tv; i++) run_vec(tv[i], 100 + i);

      // LW with a three-cycle memory stall in MEM_RD.
      run_vec(mk(I_LW, 0,1, 0,  1,1,1,0,0,  0,0,0,1,0, 10), 200);
      run_vec(mk(I_LW, 0,1, 1,  0,0,0,0,0,  0,0,0,0,0, 10), 201);
      run_vec(mk(I_LW, 0,1, 4,  0,0,0,0,0,  0,0,0,2,0, 10), 202);
      for (int i = 0; i < 3; i++)
         run_vec(mk(I_LW, 0,0, 5,  0,0,1,0,0,  0,0,0,0,0, 10), 203 + i);
      run_vec(mk(I_LW, 0,1, 5,  0,0,1,0,0,  0,0,0,0,0, 10), 206);
      run_vec(mk(I_LW, 0,1, 7,  0,0,0,0,1,  0,1,0,0,0, 10), 207);
      run_vec(mk(I_LW, 0,0, 0,  0,0,1,0,0,  0,0,0,0,0, 11), 208);

      // Reset in the middle of a MEM_RD wait.
      run_vec(mk(I_LW, 0,1, 0,  1,1,1,0,0,  0,0,0,1,0, 11), 300);
      run_vec(mk(I_LW, 0,1, 1,  0,0,0,0,0,  0,0,0,0,0, 11), 301);
      run_vec(mk(I_LW, 0,1, 4,  0,0,0,0,0,  0,0,0,2,0, 11), 302);
      run_vec(mk(I_LW, 0,0, 5,  0,0,1,0,0,  0,0,0,0,0, 11), 303);
      pulse_reset();
      run_vec(mk(I_LW, 0,0, 0,  0,0,1,0,0,  0,0,0,0,0,  0), 304);

      // Illegal opcode: HALT with Trap held, strobes quiet even with MemReady high.
      run_vec(mk(I_BAD, 0,1, 0,  1,1,1,0,0,  0,0,0,1,0,  0), 400);
      run_vec(mk(I_BAD, 0,1, 1,  0,0,0,0,0,  0,0,0,0,0,  0), 401);
      for (int i = 0; i < 10; i++)
         run_vec(mk(I_BAD, 1,1, 15, 0,0,0,0,0,  0,0,0,0,0,  0), 402 + i);
      pulse_reset();
      run_vec(mk(I_BAD, 0,0, 0,  0,0,1,0,0,  0,0,0,0,0,  0), 420);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
